// File: rtl/f_fetch_unit_pkg.sv
// rtl/f_fetch_unit_pkg.sv - F-stage defaults, state encodings and AdEL range helper
package f_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] ADEL_PC_LO        = 32'h0000_3000;
  localparam logic [31:0] ADEL_PC_HI        = 32'h0000_6FFC;

  typedef enum logic {
    FS_FETCH = 1'b0,
    FS_HOLD  = 1'b1
  } fs_state_t;

  function automatic logic pc_adel(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < ADEL_PC_LO) || (pc > ADEL_PC_HI);
  endfunction

endpackage

// File: rtl/f_instr_buf.sv
// rtl/f_instr_buf.sv - one-entry skid buffer for a fetched word that met a stall
module f_instr_buf
  import f_fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] data_in,
  output logic [31:0] data,
  output logic        full
);

  always_ff @(posedge clk) begin
    if (reset) begin
      data <= NOP_INSTR;
      full <= 1'b0;
    end else if (load) begin
      data <= data_in;
      full <= 1'b1;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/f_fetch_unit.sv
// rtl/f_fetch_unit.sv - F stage: holds F_pc, fetches from variable-latency imem, loads F/D
// Optional FETCH_ADEL_CHECK_EN: suppress misaligned/out-of-range fetches, flag via D_exc_adel.
module f_fetch_unit
  import f_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc,
  input  logic        stall,
  output logic [31:0] F_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] D_pc,
  output logic [31:0] D_instr,
  output logic        D_valid,
  output logic        fetch_wait
`ifdef FETCH_ADEL_CHECK_EN
  ,
  output logic        D_exc_adel
`endif
);

  fs_state_t   state, state_next;
  logic        slot_adel;
  logic        slot_done;
  logic [31:0] slot_word;
  logic        d_load, d_from_buf;
  logic        buf_load, buf_clear;
  logic [31:0] buf_data;
  logic        buf_full;

`ifdef FETCH_ADEL_CHECK_EN
  assign slot_adel = pc_adel(F_pc);
`else
  assign slot_adel = 1'b0;
`endif

  // A suppressed fetch completes at once with a bubble, as if the memory had acked.
  assign slot_done = slot_adel | imem_ack;
  assign slot_word = slot_adel ? NOP_INSTR : imem_rdata;
  assign imem_addr = F_pc;

  f_instr_buf #(
    .NOP_INSTR(NOP_INSTR)
  ) u_buf (
    .clk    (clk),
    .reset  (reset),
    .load   (buf_load),
    .clear  (buf_clear),
    .data_in(slot_word),
    .data   (buf_data),
    .full   (buf_full)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= FS_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    fetch_wait = 1'b0;
    d_load     = 1'b0;
    d_from_buf = 1'b0;
    buf_load   = 1'b0;
    buf_clear  = 1'b0;
    case (state)
      FS_FETCH: begin
        imem_req   = ~slot_adel;
        fetch_wait = ~slot_done;
        if (slot_done && !stall) begin
          d_load = 1'b1;
        end else if (slot_done && stall) begin
          buf_load   = 1'b1;
          state_next = FS_HOLD;
        end
      end
      FS_HOLD: begin
        if (!stall) begin
          d_load     = 1'b1;
          d_from_buf = 1'b1;
          buf_clear  = 1'b1;
          state_next = FS_FETCH;
        end
      end
      default: state_next = FS_FETCH;
    endcase
  end

  // npc is consumed only on the cycle F_pc advances, i.e. when F/D loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      F_pc    <= RESET_PC;
      D_pc    <= RESET_PC;
      D_instr <= NOP_INSTR;
      D_valid <= 1'b0;
    end else if (d_load) begin
      F_pc    <= npc;
      D_pc    <= F_pc;
      D_instr <= (d_from_buf && buf_full) ? buf_data : slot_word;
      D_valid <= 1'b1;
    end
  end

`ifdef FETCH_ADEL_CHECK_EN
  logic hold_adel;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_adel  <= 1'b0;
      D_exc_adel <= 1'b0;
    end else begin
      if (buf_load) hold_adel <= slot_adel;
      if (d_load)   D_exc_adel <= d_from_buf ? hold_adel : slot_adel;
    end
  end
`endif

endmodule
